// File: rtl/march_bist_pkg.sv
// Shared definitions for the March BIST controller: FSM states, algorithm
// encodings and a helper that builds the all-ones read expectation.
package march_bist_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INIT_W0 = 4'd1,
    S_WAIT    = 4'd2,
    S_UP_R0   = 4'd3,
    S_UP_W1   = 4'd4,
    S_DN_R1   = 4'd5,
    S_DN_W0   = 4'd6,
    S_DN_R0   = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam logic [1:0] MODE_MATS    = 2'd0;
  localparam logic [1:0] MODE_MATS_P  = 2'd1;
  localparam logic [1:0] MODE_MATS_PP = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int unsigned MAX_PROD_W = 32;

  // Low `width` bits set; callers truncate to their product width.
  function automatic logic [MAX_PROD_W-1:0] ones_of(input int unsigned width);
    logic [MAX_PROD_W-1:0] v;
    v = {MAX_PROD_W{1'b0}};
    for (int unsigned b = 0; b < MAX_PROD_W; b++) begin
      if (b < width) v[b] = 1'b1;
      else v[b] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/march_fault_logger.sv
// Per-cell fault bookkeeping: classifies each failing read as stuck-at-0 or
// stuck-at-1 and keeps a saturating count of failing reads.
module march_fault_logger
  import march_bist_pkg::*;
#(
  parameter int N_CELLS = 256,
  parameter int PROD_W  = 4,
  parameter int CNT_W   = 16,
  parameter int ADDR_W  = $clog2(N_CELLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               rd_en,
  input  logic [PROD_W-1:0]  field,
  input  logic [PROD_W-1:0]  expected,
  input  logic [ADDR_W-1:0]  idx,
  output logic [N_CELLS-1:0] sa0_map,
  output logic [N_CELLS-1:0] sa1_map,
  output logic [CNT_W-1:0]   err_cnt
);

  logic miss_s;
  logic is_r1_s;

  // A non-zero expectation means an r1 read, so a miss there is stuck-at-0.
  always_comb begin
    miss_s  = rd_en && (field != expected);
    is_r1_s = |expected;
  end

  // Map and counter update on every failing read.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sa0_map <= {N_CELLS{1'b0}};
      sa1_map <= {N_CELLS{1'b0}};
      err_cnt <= {CNT_W{1'b0}};
    end else if (miss_s) begin
      if (is_r1_s) sa0_map[idx] <= 1'b1;
      else         sa1_map[idx] <= 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/march_bist_ctrl.sv
// March-test BIST controller (MATS / MATS+ / MATS++) for one MAC slice:
// sequences cell writes, waits out the slice read latency and logs faults.
module march_bist_ctrl
  import march_bist_pkg::*;
#(
  parameter int N_CELLS  = 256,
  parameter int PROD_W   = 4,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = $clog2(N_CELLS),
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  mode,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        mode_err,
  output logic [N_CELLS-1:0]          in_array,
  output logic [N_CELLS*PROD_W-1:0]   weight_array,
  input  logic [N_CELLS*PROD_W-1:0]   product_array,
  output logic [N_CELLS-1:0]          sa0_map,
  output logic [N_CELLS-1:0]          sa1_map,
  output logic [CNT_W-1:0]            err_cnt
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [PROD_W-1:0] ONES     = PROD_W'(ones_of(PROD_W));
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_CELLS - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

  state_t             state_r;
  state_t             ret_r;
  logic [1:0]         mode_r;
  logic [ADDR_W-1:0]  idx_r;
  logic [LAT_W-1:0]   wait_cnt_r;

  logic               accept_s;
  logic               rd_en_s;
  logic [PROD_W-1:0]  expected_s;
  logic [PROD_W-1:0]  field_s;

  assign weight_array = {(N_CELLS*PROD_W){1'b1}};

  // Read strobe and expectation derived from the current read element.
  always_comb begin
    accept_s   = 1'b0;
    rd_en_s    = 1'b0;
    expected_s = {PROD_W{1'b0}};
    field_s    = product_array[PROD_W*idx_r +: PROD_W];
    if (state_r == S_IDLE) accept_s = start;
    else accept_s = 1'b0;
    case (state_r)
      S_UP_R0, S_DN_R0: begin
        rd_en_s    = 1'b1;
        expected_s = {PROD_W{1'b0}};
      end
      S_DN_R1: begin
        rd_en_s    = 1'b1;
        expected_s = ONES;
      end
      default: begin
        rd_en_s    = 1'b0;
        expected_s = {PROD_W{1'b0}};
      end
    endcase
  end

  // March sequencer; every write detours through WAIT for READ_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      ret_r      <= S_IDLE;
      mode_r     <= MODE_MATS;
      idx_r      <= ZERO_IDX;
      wait_cnt_r <= {LAT_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mode_err   <= 1'b0;
      in_array   <= {N_CELLS{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            mode_r   <= mode;
            pass     <= 1'b0;
            mode_err <= 1'b0;
            busy     <= 1'b1;
            state_r  <= (mode == MODE_ILLEGAL) ? S_DONE : S_INIT_W0;
          end
        end
        S_INIT_W0: begin
          in_array   <= {N_CELLS{1'b0}};
          idx_r      <= ZERO_IDX;
          ret_r      <= S_UP_R0;
          wait_cnt_r <= {LAT_W{1'b0}};
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_r == LAT_W'(READ_LAT - 1)) state_r <= ret_r;
          else wait_cnt_r <= wait_cnt_r + LAT_W'(1);
        end
        S_UP_R0: state_r <= S_UP_W1;
        S_UP_W1: begin
          in_array[idx_r] <= 1'b1;
          wait_cnt_r      <= {LAT_W{1'b0}};
          state_r         <= S_WAIT;
          if (idx_r == LAST_IDX) begin
            ret_r <= S_DN_R1;
          end else begin
            idx_r <= idx_r + ADDR_W'(1);
            ret_r <= S_UP_R0;
          end
        end
        S_DN_R1: begin
          if (mode_r != MODE_MATS) state_r <= S_DN_W0;
          else if (idx_r == ZERO_IDX) state_r <= S_DONE;
          else idx_r <= idx_r - ADDR_W'(1);
        end
        S_DN_W0: begin
          in_array[idx_r] <= 1'b0;
          wait_cnt_r      <= {LAT_W{1'b0}};
          state_r         <= S_WAIT;
          if (mode_r == MODE_MATS_PP) begin
            ret_r <= S_DN_R0;
          end else if (idx_r == ZERO_IDX) begin
            ret_r <= S_DONE;
          end else begin
            idx_r <= idx_r - ADDR_W'(1);
            ret_r <= S_DN_R1;
          end
        end
        S_DN_R0: begin
          if (idx_r == ZERO_IDX) begin
            state_r <= S_DONE;
          end else begin
            idx_r   <= idx_r - ADDR_W'(1);
            state_r <= S_DN_R1;
          end
        end
        S_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          pass     <= (err_cnt == {CNT_W{1'b0}}) && (mode_r != MODE_ILLEGAL);
          mode_err <= (mode_r == MODE_ILLEGAL);
          state_r  <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  march_fault_logger #(
    .N_CELLS (N_CELLS),
    .PROD_W  (PROD_W),
    .CNT_W   (CNT_W),
    .ADDR_W  (ADDR_W)
  ) u_logger (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept_s),
    .rd_en    (rd_en_s),
    .field    (field_s),
    .expected (expected_s),
    .idx      (idx_r),
    .sa0_map  (sa0_map),
    .sa1_map  (sa1_map),
    .err_cnt  (err_cnt)
  );

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: two instances (READ_LAT=1 / CNT_W=16 and
// READ_LAT=3 / CNT_W=2) driving a fault-injecting slice model that poisons
// products until READ_LAT cycles after each in_array change.
module tb_march_bist_ctrl;

  localparam int N  = 256;
  localparam int PW = 4;

  typedef struct {
    int            k;
    int            cyc;
    logic          pass;
    logic          merr;
    logic [15:0]   err;
    logic [N-1:0]  sa0;
    logic [N-1:0]  sa1;
    logic [N-1:0]  fin;
  } exp_t;

  logic clk = 1'b0;
  logic rst_v [2];
  logic start_v [2];
  logic [1:0] mode_v [2];
  logic busy_v [2];
  logic done_v [2];
  logic pass_v [2];
  logic merr_v [2];
  logic [N-1:0] in_v [2];
  logic [N-1:0] sa0m_v [2];
  logic [N-1:0] sa1m_v [2];
  logic [N-1:0] sa0_f [2];
  logic [N-1:0] sa1_f [2];
  logic [N*PW-1:0] wt_v [2];
  logic [N*PW-1:0] prod_v [2];
  logic [15:0] err0;
  logic [1:0]  err3;
  logic [N-1:0] hist [2][1:3];

  int cyc = 0;
  int dcnt [2] = '{0, 0};
  int n_checks = 0;
  int n_fail = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  march_bist_ctrl #(.N_CELLS(N), .PROD_W(PW), .READ_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .mode(mode_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .mode_err(merr_v[0]),
    .in_array(in_v[0]), .weight_array(wt_v[0]), .product_array(prod_v[0]),
    .sa0_map(sa0m_v[0]), .sa1_map(sa1m_v[0]), .err_cnt(err0));

  march_bist_ctrl #(.N_CELLS(N), .PROD_W(PW), .READ_LAT(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .mode(mode_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .mode_err(merr_v[1]),
    .in_array(in_v[1]), .weight_array(wt_v[1]), .product_array(prod_v[1]),
    .sa0_map(sa0m_v[1]), .sa1_map(sa1m_v[1]), .err_cnt(err3));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] err_of(input int k);
    return (k == 0) ? err0 : {14'd0, err3};
  endfunction

  function automatic int exp_lat(input int m, input int l);
    case (m)
      0: return (1 + l) + N * (2 + l) + N + 1;
      1: return (1 + l) + N * (2 + l) + N * (2 + l) + 1;
      2: return (1 + l) + N * (2 + l) + N * (3 + l) + 1;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      hist[k][1] <= in_v[k];
      hist[k][2] <= hist[k][1];
      hist[k][3] <= hist[k][2];
      if (done_v[k] === 1'b1) dcnt[k] <= dcnt[k] + 1;
    end
  end

  // Slice model: product = in ? all-ones : 0, stuck-at overrides, inverted while unsettled.
  always_comb begin
    logic poison;
    logic [PW-1:0] f;
    for (int k = 0; k < 2; k++) begin
      prod_v[k] = '0;
      poison = 1'b0;
      for (int j = 1; j <= 3; j++)
        if (j <= lat_of(k) && hist[k][j] !== in_v[k]) poison = 1'b1;
      for (int i = 0; i < N; i++) begin
        f = in_v[k][i] ? 4'hF : 4'h0;
        if (sa0_f[k][i]) f = 4'h0;
        if (sa1_f[k][i]) f = 4'hF;
        if (poison) f = ~f;
        prod_v[k][PW*i +: PW] = f;
      end
    end
  end

  task automatic launch(input int k, input logic [1:0] m, input bit push);
    exp_t e;
    int c0, c1, raw, mx;
    @(negedge clk);
    mode_v[k]  = m;
    start_v[k] = 1'b1;
    if (push) begin
      c0  = $countones(sa0_f[k]);
      c1  = $countones(sa1_f[k]);
      raw = (m == 2'd3) ? 0 : (m == 2'd2) ? c0 + 2 * c1 : c0 + c1;
      mx  = (k == 0) ? 65535 : 3;
      e.k    = k;
      e.cyc  = cyc + 1 + exp_lat(int'(m), lat_of(k));
      e.err  = 16'((raw > mx) ? mx : raw);
      e.pass = (raw == 0) && (m != 2'd3);
      e.merr = (m == 2'd3);
      e.sa0  = (m == 2'd3) ? '0 : sa0_f[k];
      e.sa1  = (m == 2'd3) ? '0 : sa1_f[k];
      e.fin  = (m == 2'd0) ? '1 : (m == 2'd3) ? in_v[k] : '0;
      sb.push_back(e);
    end
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done_v[k] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL scoreboard_empty dut%0d: no expectation queued", k);
    end else if (!seen) begin
      e = sb.pop_front();
      n_fail++; $display("FAIL done_timeout dut%0d: no done within %0d cycles", k, budget);
    end else begin
      e = sb.pop_front();
      n_checks += 7;
      if (cyc !== e.cyc) begin n_fail++; $display("FAIL latency dut%0d: got cycle %0d want %0d", k, cyc, e.cyc); end
      if (pass_v[k] !== e.pass) begin n_fail++; $display("FAIL pass dut%0d: got %b want %b", k, pass_v[k], e.pass); end
      if (merr_v[k] !== e.merr) begin n_fail++; $display("FAIL mode_err dut%0d: got %b want %b", k, merr_v[k], e.merr); end
      if (err_of(k) !== e.err) begin n_fail++; $display("FAIL err_cnt dut%0d: got %0d want %0d", k, err_of(k), e.err); end
      if (sa0m_v[k] !== e.sa0) begin n_fail++; $display("FAIL sa0_map dut%0d: got %h want %h", k, sa0m_v[k], e.sa0); end
      if (sa1m_v[k] !== e.sa1) begin n_fail++; $display("FAIL sa1_map dut%0d: got %h want %h", k, sa1m_v[k], e.sa1); end
      if (in_v[k] !== e.fin) begin n_fail++; $display("FAIL in_array_final dut%0d: got %h want %h", k, in_v[k], e.fin); end
      @(negedge clk);
      n_checks++;
      if (done_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
        n_fail++; $display("FAIL done_pulse dut%0d: got done=%b busy=%b want 0 0", k, done_v[k], busy_v[k]);
      end
    end
  endtask

  task automatic set_faults(input int k, input logic [N-1:0] s0, input logic [N-1:0] s1);
    sa0_f[k] = s0;
    sa1_f[k] = s1;
  endtask

  task automatic test_reset();
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks += 4;
      if ({busy_v[k], done_v[k], pass_v[k], merr_v[k]} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_flags dut%0d: got %b%b%b%b want 0000", k, busy_v[k], done_v[k], pass_v[k], merr_v[k]);
      end
      if (in_v[k] !== '0) begin n_fail++; $display("FAIL reset_in_array dut%0d: got %h want 0", k, in_v[k]); end
      if ({sa0m_v[k], sa1m_v[k]} !== '0 || err_of(k) !== 16'd0) begin
        n_fail++; $display("FAIL reset_log dut%0d: got maps %h %h err %0d want 0", k, sa0m_v[k], sa1m_v[k], err_of(k));
      end
      if (wt_v[k] !== '1) begin n_fail++; $display("FAIL weight_ones dut%0d: got %h want all ones", k, wt_v[k]); end
    end
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_faults(input logic [1:0] m);
    logic [N-1:0] s0, s1;
    s0 = '0; s1 = '0;
    s0[7] = 1'b1; s0[123] = 1'b1; s1[42] = 1'b1; s1[200] = 1'b1;
    set_faults(0, s0, s1);
    launch(0, m, 1'b1);
    wait_done(0, 4000);
  endtask

  task automatic test_mats_clean();
    set_faults(0, '0, '0);
    launch(0, 2'd0, 1'b1);
    wait_done(0, 4000);
  endtask

  task automatic test_illegal_mode();
    launch(0, 2'd3, 1'b1);
    n_checks++;
    if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL illegal_accept: got busy=%b done=%b want 1 0", busy_v[0], done_v[0]);
    end
    wait_done(0, 10);
  endtask

  task automatic test_abort_reset();
    bit seen;
    int d0;
    logic [N-1:0] s0, s1;
    s0 = '0; s1 = '0; s0[7] = 1'b1; s1[42] = 1'b1;
    set_faults(0, s0, s1);
    launch(0, 2'd0, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (in_v[0][99] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL abort_reach_idx100: in_array[99] never set"); end
    void'(sb.pop_back());
    d0 = dcnt[0];
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    n_checks += 2;
    if ({busy_v[0], done_v[0], pass_v[0], merr_v[0]} !== 4'b0000 || in_v[0] !== '0) begin
      n_fail++; $display("FAIL abort_state: got busy=%b done=%b in=%h want 0 0 0", busy_v[0], done_v[0], in_v[0]);
    end
    if ({sa0m_v[0], sa1m_v[0]} !== '0 || err0 !== 16'd0) begin
      n_fail++; $display("FAIL abort_log: got maps %h %h err %0d want 0", sa0m_v[0], sa1m_v[0], err0);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (dcnt[0] != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", dcnt[0] - d0); end
    launch(0, 2'd1, 1'b1);
    wait_done(0, 4000);
  endtask

  task automatic test_back_to_back();
    int d0;
    set_faults(0, '0, '0);
    d0 = dcnt[0];
    launch(0, 2'd0, 1'b1);
    repeat (50) @(negedge clk);
    launch(0, 2'd2, 1'b0);
    wait_done(0, 4000);
    repeat (5) @(negedge clk);
    n_checks++;
    if (dcnt[0] - d0 != 1) begin n_fail++; $display("FAIL back_to_back_done_count: got %0d want 1", dcnt[0] - d0); end
  endtask

  task automatic test_read_lat3();
    logic [N-1:0] s0, s1;
    set_faults(1, '0, '0);
    launch(1, 2'd0, 1'b1);
    wait_done(1, 4000);
    launch(1, 2'd1, 1'b1);
    wait_done(1, 4000);
    s0 = '0; s1 = '0;
    s0[0] = 1'b1; s0[255] = 1'b1; s1[1] = 1'b1; s1[128] = 1'b1; s1[254] = 1'b1;
    set_faults(1, s0, s1);
    launch(1, 2'd2, 1'b1);
    wait_done(1, 4000);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; start_v[k] = 1'b0; mode_v[k] = 2'd0;
      sa0_f[k] = '0; sa1_f[k] = '0;
    end
    test_reset();
    test_faults(2'd2);
    test_mats_clean();
    test_illegal_mode();
    test_faults(2'd0);
    test_abort_reset();
    test_back_to_back();
    test_read_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
